seq_mult: RTL and testbench
===========================

# seq_mult

Sequential shift-and-add multiplier, parametrised in operand width, with a start/done handshake and a run-time signed/unsigned mode. It computes one partial product per clock instead of unrolling the whole product in one combinational cone, which trades latency for area and timing at wide operand sizes. It is the registered, multi-cycle successor to the team's combinational 8-bit multiplier. It sits behind any datapath controller that can issue a start strobe and wait for done.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- signed_mode  in  1  1 = operands and product are two's complement, 0 = unsigned; sampled together with start.
- A  in  WIDTH  multiplicand; sampled with start.
- B  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress (RUN or FINISH).
- done  out  1  one-cycle pulse; P is valid from this cycle.
- P  out  2*WIDTH  product; holds its value until the next FINISH writes it.

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE, start=1:
  - Latch the operand magnitudes: |A| and |B| if signed_mode, else A and B raw.
  - Latch sign = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]).
  - Clear the accumulator (2*WIDTH bits) and the iteration counter ($clog2(WIDTH+1) bits).
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, every cycle:
  - If the multiplier-register LSB is 1, add the multiplicand register (zero-extended to 2*WIDTH) to the accumulator.
  - Shift the multiplicand register left 1 and the multiplier register right 1.
  - Increment the counter.
  - After exactly WIDTH RUN cycles, go to FINISH.
- FINISH:
  - P <= sign ? (two's-complement negate of accumulator) : accumulator.
  - done <= 1.
  - Go to IDLE.
- Arithmetic:
  - Magnitude of the most negative operand (−2^(WIDTH−1)) is 2^(WIDTH−1) and fits unsigned in WIDTH bits. No overflow is possible.
  - Every product fits in 2*WIDTH bits in both modes.
- start, A, B and signed_mode are ignored while busy. Operands are latched, so input changes mid-operation have no effect.
- Reset, including mid-operation:
  - Forces IDLE immediately.
  - Outputs: busy=0, done=0, P=0.
  - Internal accumulator, operand registers, counter and sign are all cleared.
- start=1 held continuously: a new operation starts on every IDLE cycle (back-to-back).

## Timing
- Reference point: start high in cycle 0, sampled at the end of cycle 0.
- Cycles 1..WIDTH: RUN. Cycle WIDTH+1: FINISH.
- busy is high in cycles 1..WIDTH+1.
- done is high in cycle WIDTH+2 only. P is updated at the start of cycle WIDTH+2.
- Cycle WIDTH+2 is IDLE, so start there is accepted: the next done arrives in cycle 2*WIDTH+4.
- Throughput is one product per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package mult_pkg holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, FINISH=2'd2);
  - a helper function for the counter width, clog2(WIDTH+1).
- One sub-module: twos_negate #(N). It is a combinational conditional negate (out = neg ? ~in+1 : in).
  - Instantiated twice: at WIDTH for the operand magnitudes, and at 2*WIDTH for the result sign fix.
- Control FSM, counter and accumulator live in seq_mult itself.

## Test plan
- WIDTH=8, unsigned: A=13, B=11 -> P=0x008F. done is a single pulse in cycle 10, busy is high in cycles 1..9.
- Unsigned extremes: A=255, B=255 -> P=0xFE01. A=0, B=200 -> P=0x0000, still with full latency.
- Signed: A=−3 (0xFD), B=5 -> P=0xFFF1. A=−128 (0x80), B=−128 (0x80) -> P=0x4000. A=−128, B=1 -> P=0xFF80.
- Start ignored while busy: start=1 with A=7, B=7 in cycle 0, then start=1 with A=2, B=2 in cycle 4 -> one done only in cycle 10, P=0x0031. Changing A/B during RUN has no effect.
- Back-to-back: start held high with A=3, B=4 and then A=6, B=9 presented in cycle 10 -> done in cycle 10 with P=0x000C, then done in cycle 20 with P=0x0036.
- Reset mid-operation: assert rst_n=0 in cycle 5 -> busy, done and P go to 0 immediately. A start after release completes normally with the correct product.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding and counter sizing.
package mult_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      RUN    = ST_RUN,
      FINISH = ST_FINISH
   } state_e;

   // Counter must hold values 0..width inclusive.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Start/done handshake and operand/product bus for seq_mult.
interface seq_mult_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   P;

   modport master (
      output start, signed_mode, A, B,
      input  busy, done, P
   );

   modport slave (
      input  start, signed_mode, A, B,
      output busy, done, P
   );
endinterface

// File: rtl/seq_mult_twos_negate.sv
// Combinational conditional two's-complement negate.
module twos_negate #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] din,
   input  logic         neg,
   output logic [N-1:0] dout
);
   assign dout = neg ? (~din + N'(1)) : din;
endmodule

// File: rtl/seq_mult.sv
// Shift-and-add multiplier: one partial product per RUN cycle, signed via magnitude + sign fix.
module seq_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_mult_if.slave  bus
);
   import mult_pkg::*;

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = cnt_width(WIDTH);

   state_e            state_q, state_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sign_q, sign_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [PW-1:0]     p_q, p_d;

   logic [WIDTH-1:0]  abs_a, abs_b;
   logic [PW-1:0]     p_fix;

   twos_negate #(.N(WIDTH)) u_abs_a (
      .din  (bus.A),
      .neg  (bus.signed_mode & bus.A[WIDTH-1]),
      .dout (abs_a)
   );

   twos_negate #(.N(WIDTH)) u_abs_b (
      .din  (bus.B),
      .neg  (bus.signed_mode & bus.B[WIDTH-1]),
      .dout (abs_b)
   );

   twos_negate #(.N(PW)) u_fix_p (
      .din  (acc_q),
      .neg  (sign_q),
      .dout (p_fix)
   );

   // Next-state, datapath and output logic.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      done_d   = 1'b0;
      p_d      = p_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d  = PW'(abs_a);
               mplier_d = abs_b;
               sign_d   = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
         end
         FINISH: begin
            p_d     = p_fix;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         p_q      <= p_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.P    = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: vector table plus busy-ignore, back-to-back and mid-run reset sequences.
module tb_seq_mult;
   localparam int unsigned WIDTH = 8;
   localparam int NV = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seq_mult_if #(.WIDTH(WIDTH)) bus ();
   seq_mult #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic [15:0] p;
      string       name;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation in the current cycle (cycle 0) and follow it through cycle WIDTH+2.
   task automatic do_op(input vec_t v);
      logic [31:0] ob, od, eb, ed;
      ob = '0; od = '0; eb = '0; ed = '0;
      bus.A = v.a; bus.B = v.b; bus.signed_mode = v.sm; bus.start = 1'b1;
      for (int c = 1; c <= int'(WIDTH) + 2; c++) begin
         next_cycle();
         if (c == 1) begin
            bus.start = 1'b0;
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            bus.signed_mode = ~v.sm;
         end
         @(negedge clk);
         ob[c] = bus.busy;
         od[c] = bus.done;
         eb[c] = (c <= int'(WIDTH) + 1);
         ed[c] = (c == int'(WIDTH) + 2);
      end
      check({v.name, " busy"}, ob, eb);
      check({v.name, " done"}, od, ed);
      check({v.name, " P"}, 32'(bus.P), 32'(v.p));
   endtask

   initial begin
      logic [31:0] od, ed;
      vec_t rv;

      vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, "u_13x11"};
      vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, "u_255x255"};
      vecs[2] = '{8'd0,   8'd200, 1'b0, 16'h0000, "u_0x200"};
      vecs[3] = '{8'hFD,  8'd5,   1'b0, 16'h04F1, "u_253x5"};
      vecs[4] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, "s_m3x5"};
      vecs[5] = '{8'h80,  8'h80,  1'b1, 16'h4000, "s_m128xm128"};
      vecs[6] = '{8'h80,  8'h01,  1'b1, 16'hFF80, "s_m128x1"};
      vecs[7] = '{8'h7F,  8'h7F,  1'b1, 16'h3F01, "s_127x127"};
      vecs[8] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, "s_m1xm1"};
      vecs[9] = '{8'd5,   8'hFD,  1'b1, 16'hFFF1, "s_5xm3"};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.signed_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset P", 32'(bus.P), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) do_op(vecs[i]);

      // Start during RUN must be ignored; only the 7x7 result appears.
      od = '0; ed = '0;
      bus.A = 8'd7; bus.B = 8'd7; bus.signed_mode = 1'b0; bus.start = 1'b1;
      for (int c = 1; c <= int'(WIDTH) + 14; c++) begin
         next_cycle();
         if (c == 4) begin
            bus.start = 1'b1; bus.A = 8'd2; bus.B = 8'd2;
         end else begin
            bus.start = 1'b0; bus.A = 8'(c); bus.B = 8'(c * 3);
         end
         @(negedge clk);
         od[c] = bus.done;
         ed[c] = (c == int'(WIDTH) + 2);
         if (c == int'(WIDTH) + 2) check("ignore P", 32'(bus.P), 32'h0031);
      end
      check("ignore done", od, ed);

      // Start held high: operations chain with no idle gap.
      od = '0; ed = '0;
      bus.A = 8'd3; bus.B = 8'd4; bus.signed_mode = 1'b0; bus.start = 1'b1;
      for (int c = 1; c <= 2 * int'(WIDTH) + 4; c++) begin
         next_cycle();
         if (c == int'(WIDTH) + 2) begin
            bus.A = 8'd6; bus.B = 8'd9;
         end
         if (c == 2 * int'(WIDTH) + 4) bus.start = 1'b0;
         @(negedge clk);
         od[c] = bus.done;
         ed[c] = (c == int'(WIDTH) + 2) || (c == 2 * int'(WIDTH) + 4);
         if (c == int'(WIDTH) + 2) check("b2b P1", 32'(bus.P), 32'h000C);
         if (c == 2 * int'(WIDTH) + 4) check("b2b P2", 32'(bus.P), 32'h0036);
      end
      check("b2b done", od, ed);

      // Asynchronous reset in the middle of a run.
      bus.A = 8'd13; bus.B = 8'd11; bus.signed_mode = 1'b0; bus.start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         bus.start = 1'b0;
         if (c == 4) begin
            @(negedge clk);
            check("pre-reset busy", 32'(bus.busy), 32'd1);
         end
      end
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(bus.busy), 32'd0);
      check("midrst done", 32'(bus.done), 32'd0);
      check("midrst P", 32'(bus.P), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rv = '{8'd9, 8'd9, 1'b0, 16'h0051, "post_rst_9x9"};
      do_op(rv);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
      $fatal(1);
   end
endmodule
